// File: rtl/usr_serial_ctrl.sv
// Sequencer driving an external universal shift register for parallel<->serial conversion.
// Optional abort input is enabled by defining USR_CTRL_ABORT_EN.
module usr_serial_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef USR_CTRL_ABORT_EN
   input  logic             abort,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             tx_bit,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic             rx_bit,
   input  logic             rx_bit_valid,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             done,
   output logic [1:0]       usr_sel,
   output logic [WIDTH-1:0] usr_d,
   output logic             usr_sr_in,
   output logic             usr_sl_in,
   input  logic [WIDTH-1:0] usr_q
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_RIGHT = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       op_reg, op_next;
   logic [WIDTH-1:0] word_reg, word_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             beat;
   logic             abort_hit;
   logic [1:0]       shift_sel;

`ifdef USR_CTRL_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // op[0] selects direction for both TX and RX: 0 = right (LSB side), 1 = left.
   assign shift_sel = op_reg[0] ? SEL_LEFT : SEL_RIGHT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         word_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         word_reg  <= word_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      word_next  = word_reg;
      cnt_next   = cnt_reg;
      beat       = 1'b0;
      cmd_ready  = 1'b0;
      tx_bit     = 1'b0;
      tx_valid   = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = '0;
      done       = 1'b0;
      usr_sel    = SEL_HOLD;
      usr_d      = word_reg;
      usr_sr_in  = 1'b0;
      usr_sl_in  = 1'b0;

      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_next   = cmd_op;
               word_next = cmd_data;
               if (cmd_op[1]) begin
                  state_next = SHIFT;
                  cnt_next   = CW'(WIDTH);
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (abort_hit) begin
               state_next = IDLE;
            end else begin
               usr_sel    = SEL_LOAD;
               state_next = SHIFT;
               cnt_next   = CW'(WIDTH);
            end
         end
         SHIFT: begin
            if (op_reg[1]) begin
               usr_sr_in = rx_bit;
               usr_sl_in = rx_bit;
               beat      = rx_bit_valid;
            end else begin
               tx_valid = 1'b1;
               tx_bit   = op_reg[0] ? usr_q[WIDTH-1] : usr_q[0];
               beat     = tx_ready;
            end
            if (abort_hit) begin
               state_next = IDLE;
            end else if (beat) begin
               usr_sel  = shift_sel;
               cnt_next = cnt_reg - CW'(1);
               if (cnt_reg == CW'(1))
                  state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (op_reg[1]) begin
               rx_valid = 1'b1;
               rx_data  = usr_q;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Keep the USR contents frozen while reset is held.
      if (!rst_n)
         usr_sel = SEL_HOLD;
   end

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// Directed bench for usr_serial_ctrl with a behavioural 4-bit USR attached.
`timescale 1ns/1ps
module tb_usr_serial_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic         tx_bit, tx_valid, tx_ready;
   logic         rx_bit, rx_bit_valid, rx_valid;
   logic [W-1:0] rx_data;
   logic         done;
   logic [1:0]   usr_sel;
   logic [W-1:0] usr_d;
   logic         usr_sr_in, usr_sl_in;
   logic [W-1:0] usr_q = '0;
`ifdef USR_CTRL_ABORT_EN
   logic         abort;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   usr_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef USR_CTRL_ABORT_EN
      .abort(abort),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid), .rx_valid(rx_valid), .rx_data(rx_data),
      .done(done), .usr_sel(usr_sel), .usr_d(usr_d),
      .usr_sr_in(usr_sr_in), .usr_sl_in(usr_sl_in), .usr_q(usr_q)
   );

   // Behavioural universal shift register: right shift enters at MSB, left shift at LSB.
   always @(posedge clk) begin
      case (usr_sel)
         2'b01:   usr_q <= {usr_sr_in, usr_q[W-1:1]};
         2'b10:   usr_q <= {usr_q[W-2:0], usr_sl_in};
         2'b11:   usr_q <= usr_d;
         default: usr_q <= usr_q;
      endcase
   end

   // Inputs change and outputs are sampled in the low phase, between rising edges.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
      tx_ready = 1'b0; rx_bit = 1'b0; rx_bit_valid = 1'b0;
`ifdef USR_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      tick; tick;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if ({tx_valid, tx_bit, rx_valid, done} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {tx_valid, tx_bit, rx_valid, done}); end
      checks++; if (rx_data !== 4'h0) begin errors++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
      checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL reset_usr_sel got=%b exp=00", usr_sel); end
      checks++; if ({usr_d, usr_sr_in, usr_sl_in} !== 6'b0) begin errors++; $display("FAIL reset_usr_d_sin got=%b exp=000000", {usr_d, usr_sr_in, usr_sl_in}); end
      rst_n = 1'b1;
      $display("txn reset: outputs checked");
   endtask

   task automatic test_tx_lsb;
      logic [3:0] exp_bits;
      exp_bits = 4'b1011; // sent LSB first: 1,1,0,1
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1011; tx_ready = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL txl_ready_idle got=%b exp=1", cmd_ready); end
      tick;
      // Hold a competing request to confirm nothing is accepted while busy.
      cmd_op = 2'b10; cmd_data = 4'b0000;
      #1;
      checks++; if (usr_sel !== 2'b11 || usr_d !== 4'b1011) begin errors++; $display("FAIL txl_load got sel=%b d=%b exp sel=11 d=1011", usr_sel, usr_d); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL txl_busy_ready got=%b exp=0", cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 3) cmd_valid = 1'b0;
         #1;
         checks++; if (tx_valid !== 1'b1 || tx_bit !== exp_bits[i] || usr_sel !== 2'b01) begin
            errors++; $display("FAIL txl_bit%0d got v=%b b=%b sel=%b exp v=1 b=%b sel=01", i, tx_valid, tx_bit, usr_sel, exp_bits[i]);
         end
      end
      tick;
      checks++; if (done !== 1'b1 || rx_valid !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL txl_done got done=%b rxv=%b txv=%b exp 1 0 0", done, rx_valid, tx_valid); end
      tick;
      checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL txl_idle got ready=%b done=%b exp 1 0", cmd_ready, done); end
      $display("txn tx_lsb data=1011 complete");
   endtask

   task automatic test_tx_msb_stall;
      logic [5:0] rdy, exp_bit;
      logic [1:0] exp_sel [6];
      rdy     = 6'b111001; // index 0 first: beat, stall, stall, beat, beat, beat
      exp_bit = 6'b110001; // bits 1,0,0,0,1,1
      exp_sel = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b1011; tx_ready = 1'b0;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         tx_ready = rdy[i];
         #1;
         checks++; if (tx_valid !== 1'b1 || tx_bit !== exp_bit[i] || usr_sel !== exp_sel[i] || done !== 1'b0) begin
            errors++; $display("FAIL txm_cyc%0d got v=%b b=%b sel=%b done=%b exp v=1 b=%b sel=%b done=0", i, tx_valid, tx_bit, usr_sel, done, exp_bit[i], exp_sel[i]);
         end
      end
      tick;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL txm_done got=%b exp=1", done); end
      tick;
      $display("txn tx_msb data=1011 with 2-cycle stall complete");
   endtask

   task automatic test_rx_lsb;
      logic [5:0] vld, bits;
      vld  = 6'b110101; // beats on cycles 0,2,4,5
      bits = 6'b100001; // beat bits 1,0,0,1
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'b1111; tx_ready = 1'b0;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rx_bit_valid = vld[i]; rx_bit = bits[i];
         #1;
         checks++; if (usr_sel !== (vld[i] ? 2'b01 : 2'b00) || usr_sr_in !== bits[i] || rx_valid !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL rxl_cyc%0d got sel=%b sr=%b rxv=%b txv=%b exp sel=%b sr=%b rxv=0 txv=0", i, usr_sel, usr_sr_in, rx_valid, tx_valid, vld[i] ? 2'b01 : 2'b00, bits[i]);
         end
         tick;
      end
      rx_bit_valid = 1'b0; rx_bit = 1'b0;
      #1;
      checks++; if (rx_valid !== 1'b1 || rx_data !== 4'b1001 || done !== 1'b1) begin errors++; $display("FAIL rxl_word got rxv=%b data=%b done=%b exp 1 1001 1", rx_valid, rx_data, done); end
      tick;
      checks++; if (rx_valid !== 1'b0 || rx_data !== 4'b0000) begin errors++; $display("FAIL rxl_pulse got rxv=%b data=%b exp 0 0000", rx_valid, rx_data); end
      $display("txn rx_lsb bits 1,0,0,1 received");
   endtask

   task automatic test_rx_msb;
      logic [3:0] bits;
      bits = 4'b0011; // beat bits 1,1,0,0
      cmd_valid = 1'b1; cmd_op = 2'b11;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rx_bit_valid = 1'b1; rx_bit = bits[i];
         #1;
         checks++; if (usr_sel !== 2'b10 || usr_sl_in !== bits[i]) begin errors++; $display("FAIL rxm_cyc%0d got sel=%b sl=%b exp 10 %b", i, usr_sel, usr_sl_in, bits[i]); end
         tick;
      end
      rx_bit_valid = 1'b0;
      #1;
      checks++; if (rx_valid !== 1'b1 || rx_data !== 4'b1100) begin errors++; $display("FAIL rxm_word got rxv=%b data=%b exp 1 1100", rx_valid, rx_data); end
      tick;
      $display("txn rx_msb bits 1,1,0,0 received");
   endtask

   task automatic test_reset_mid;
      logic [3:0] exp_bits;
      exp_bits = 4'b0110; // TX_MSB of 0110 sends 0,1,1,0
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1011; tx_ready = 1'b1;
      tick;             // LOAD
      cmd_valid = 1'b0;
      tick; tick;       // two beats
      rst_n = 1'b0;
      #1;
      checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL rstmid_sel got=%b exp=00", usr_sel); end
      tick;
      checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || tx_valid !== 1'b0 || usr_d !== 4'b0000) begin
         errors++; $display("FAIL rstmid_idle got ready=%b done=%b txv=%b d=%b exp 1 0 0 0000", cmd_ready, done, tx_valid, usr_d);
      end
      rst_n = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b0110;
      tick;
      cmd_valid = 1'b0;
      #1;
      checks++; if (usr_sel !== 2'b11 || usr_d !== 4'b0110) begin errors++; $display("FAIL rstmid_accept got sel=%b d=%b exp 11 0110", usr_sel, usr_d); end
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (tx_bit !== exp_bits[3-i]) begin errors++; $display("FAIL rstmid_bit%0d got=%b exp=%b", i, tx_bit, exp_bits[3-i]); end
      end
      tick;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got=%b exp=1", done); end
      tick;
      $display("txn reset mid-TX then tx_msb data=0110 complete");
   endtask

`ifdef USR_CTRL_ABORT_EN
   task automatic test_abort;
      cmd_valid = 1'b1; cmd_op = 2'b10;
      tick;
      cmd_valid = 1'b0; rx_bit_valid = 1'b1; rx_bit = 1'b1;
      tick;             // one beat taken
      rx_bit_valid = 1'b1; abort = 1'b1;
      #1;
      checks++; if (usr_sel !== 2'b00) begin errors++; $display("FAIL abort_sel got=%b exp=00", usr_sel); end
      tick;
      abort = 1'b0; rx_bit_valid = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1 || rx_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got ready=%b rxv=%b done=%b exp 1 0 0", cmd_ready, rx_valid, done); end
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b0001; tx_ready = 1'b1;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (tx_bit !== (i == 0)) begin errors++; $display("FAIL abort_tx_bit%0d got=%b exp=%b", i, tx_bit, i == 0); end
      end
      tick;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_tx_done got=%b exp=1", done); end
      tick;
      $display("txn abort during rx then tx complete");
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset;
      test_tx_lsb;
      test_tx_msb_stall;
      test_rx_lsb;
      test_rx_msb;
      test_reset_mid;
`ifdef USR_CTRL_ABORT_EN
      test_abort;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
